// File: rtl/ped_pkg.sv
// Shared definitions for the pedestrian request unit: FSM encodings,
// default parameter values and the press-count width.
package ped_pkg;

  localparam logic [1:0] PED_IDLE    = 2'd0;
  localparam logic [1:0] PED_PENDING = 2'd1;
  localparam logic [1:0] PED_HOLDOFF = 2'd2;

  localparam int PED_DEBOUNCE_DEF = 4;
  localparam int PED_HOLDOFF_DEF  = 8;
  localparam int PED_BLINK_DEF    = 2;
  localparam int PED_CNT_W        = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = PED_IDLE,
    ST_PENDING = PED_PENDING,
    ST_HOLDOFF = PED_HOLDOFF
  } ped_state_e;

  // The press counter sticks at all-ones rather than wrapping.
  function automatic logic [PED_CNT_W-1:0] satInc(input logic [PED_CNT_W-1:0] v);
    return (v == {PED_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ped_debounce.sv
// Button conditioning: two-flop synchroniser, stable-count debounce and a
// one-cycle pulse on each debounced rising edge.
module ped_debounce
  import ped_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = PED_DEBOUNCE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_db,
  output logic press_pulse
);

  logic       sync1_q;
  logic       sync2_q;
  logic       btnDb_q;
  logic       btnDbPrev_q;
  logic [3:0] dbCnt_q;
  logic [3:0] dbCnt_d;
  logic       btnDb_d;

  // The debounced level only flips after the synchronised input has
  // disagreed with it for DEBOUNCE_CYCLES consecutive samples.
  always_comb begin
    dbCnt_d = '0;
    btnDb_d = btnDb_q;
    if (sync2_q != btnDb_q) begin
      if (dbCnt_q == 4'(DEBOUNCE_CYCLES - 1)) begin
        btnDb_d = sync2_q;
      end else begin
        dbCnt_d = dbCnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      btnDb_q     <= 1'b0;
      btnDbPrev_q <= 1'b0;
      dbCnt_q     <= '0;
    end else begin
      sync1_q     <= btn_raw;
      sync2_q     <= sync1_q;
      btnDb_q     <= btnDb_d;
      btnDbPrev_q <= btnDb_q;
      dbCnt_q     <= dbCnt_d;
    end
  end

  assign btn_db      = btnDb_q;
  assign press_pulse = btnDb_q & ~btnDbPrev_q;

endmodule

// File: rtl/ped_request_unit.sv
// Pedestrian request unit: debounced press -> pending request held on a
// req/ack handshake, hold-off after service. PED_WAIT_BLINK_EN blinks WAIT.
module ped_request_unit
  import ped_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = PED_DEBOUNCE_DEF,
  parameter int HOLDOFF_CYCLES  = PED_HOLDOFF_DEF,
  parameter int BLINK_CYCLES    = PED_BLINK_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btn_raw,
  input  logic                 ped_ack,
  output logic                 ped_req,
  output logic                 wait_led,
  output logic [PED_CNT_W-1:0] press_count
);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 15) begin : gBadDebounce
    $error("ped_request_unit: DEBOUNCE_CYCLES out of range 2..15");
  end
  if (HOLDOFF_CYCLES < 1 || HOLDOFF_CYCLES > 255) begin : gBadHoldoff
    $error("ped_request_unit: HOLDOFF_CYCLES out of range 1..255");
  end
  if (BLINK_CYCLES < 1 || BLINK_CYCLES > 15) begin : gBadBlink
    $error("ped_request_unit: BLINK_CYCLES out of range 1..15");
  end

  ped_state_e           state_q;
  logic [PED_CNT_W-1:0] pressCount_q;
  logic [7:0]           holdCnt_q;
  logic                 btnDb;
  logic                 pressPulse;
  logic                 press;

  ped_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) uDebounce (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .btn_db     (btnDb),
    .press_pulse(pressPulse)
  );

  assign press = pressPulse & btnDb;

  // Request FSM; ack takes priority over a coincident press in PENDING.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pressCount_q <= '0;
      holdCnt_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (press) begin
            state_q      <= ST_PENDING;
            pressCount_q <= PED_CNT_W'(1);
          end
        end
        ST_PENDING: begin
          if (ped_ack) begin
            state_q      <= ST_HOLDOFF;
            pressCount_q <= '0;
            holdCnt_q    <= '0;
          end else if (press) begin
            pressCount_q <= satInc(pressCount_q);
          end
        end
        ST_HOLDOFF: begin
          if (holdCnt_q == 8'(HOLDOFF_CYCLES - 1)) begin
            state_q   <= ST_IDLE;
            holdCnt_q <= '0;
          end else begin
            holdCnt_q <= holdCnt_q + 8'd1;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          pressCount_q <= '0;
          holdCnt_q    <= '0;
        end
      endcase
    end
  end

  assign ped_req     = (state_q == ST_PENDING);
  assign press_count = pressCount_q;

`ifdef PED_WAIT_BLINK_EN
  logic [3:0] blinkCnt_q;
  logic       blink_q;

  // Blink phase is primed to 1 on the IDLE->PENDING edge so the LED lights
  // in the same cycle ped_req rises.
  always_ff @(posedge clk) begin
    if (rst) begin
      blinkCnt_q <= '0;
      blink_q    <= 1'b0;
    end else if (state_q != ST_PENDING) begin
      blinkCnt_q <= '0;
      blink_q    <= (state_q == ST_IDLE) && press;
    end else if (ped_ack) begin
      blinkCnt_q <= '0;
      blink_q    <= 1'b0;
    end else if (blinkCnt_q == 4'(BLINK_CYCLES - 1)) begin
      blinkCnt_q <= '0;
      blink_q    <= ~blink_q;
    end else begin
      blinkCnt_q <= blinkCnt_q + 4'd1;
    end
  end

  assign wait_led = (state_q == ST_PENDING) & blink_q;
`else
  assign wait_led = (state_q == ST_PENDING);
`endif

endmodule

// File: tb/tb_ped_request_unit.sv
// Scoreboard bench for ped_request_unit: expectations are queued as stimulus
// is applied and popped one per clock edge. Honours PED_WAIT_BLINK_EN.
module tb_ped_request_unit;
  import ped_pkg::*;

`ifdef PED_WAIT_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  typedef struct {
    string      tag;
    logic       req;
    logic [3:0] cnt;
    logic       led;
    bit         ledKnown;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_raw = 1'b0;
  logic       ped_ack = 1'b0;
  logic       ped_req;
  logic       wait_led;
  logic [3:0] press_count;

  exp_t expQ[$];
  int   total = 0;
  int   bad = 0;

  ped_request_unit dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .ped_ack    (ped_ack),
    .ped_req    (ped_req),
    .wait_led   (wait_led),
    .press_count(press_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // With blinking on, the LED phase inside PENDING is only checked by test_blink.
  task automatic expectNext(input string tag, input logic req, input logic [3:0] cnt);
    exp_t e;
    e.tag      = tag;
    e.req      = req;
    e.cnt      = cnt;
    e.led      = req;
    e.ledKnown = !(BLINK_ON && req);
    expQ.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    btn_raw = 1'b0;
    ped_ack = 1'b0;
    step();
    expectNext("reset", 1'b0, 4'd0);
    while (expQ.size() > 0) begin
      step();
      e = expQ.pop_front();
      total++;
      if (ped_req !== e.req) begin bad++; $display("[TB] FAIL %s ped_req got=%b want=%b", e.tag, ped_req, e.req); end
      total++;
      if (press_count !== e.cnt) begin bad++; $display("[TB] FAIL %s press_count got=%0d want=%0d", e.tag, press_count, e.cnt); end
      total++;
      if (wait_led !== e.led) begin bad++; $display("[TB] FAIL %s wait_led got=%b want=%b", e.tag, wait_led, e.led); end
    end
    rst = 1'b0;
  endtask

  task automatic test_glitch();
    exp_t e;
    btn_raw = 1'b1;
    for (int i = 0; i < 3; i++) expectNext("glitch_high", 1'b0, 4'd0);
    while (expQ.size() > 0) begin
      step();
      e = expQ.pop_front();
      total++;
      if (ped_req !== e.req) begin bad++; $display("[TB] FAIL %s ped_req got=%b want=%b", e.tag, ped_req, e.req); end
    end
    btn_raw = 1'b0;
    for (int i = 0; i < 10; i++) expectNext("glitch_after", 1'b0, 4'd0);
    while (expQ.size() > 0) begin
      step();
      e = expQ.pop_front();
      total++;
      if (ped_req !== e.req) begin bad++; $display("[TB] FAIL %s ped_req got=%b want=%b", e.tag, ped_req, e.req); end
      total++;
      if (press_count !== e.cnt) begin bad++; $display("[TB] FAIL %s press_count got=%0d want=%0d", e.tag, press_count, e.cnt); end
    end
  endtask

  task automatic test_latency();
    exp_t e;
    btn_raw = 1'b1;
    for (int k = 1; k <= 6; k++) expectNext($sformatf("latency_edge%0d", k), 1'b0, 4'd0);
    expectNext("latency_edge7", 1'b1, 4'd1);
    while (expQ.size() > 0) begin
      step();
      e = expQ.pop_front();
      total++;
      if (ped_req !== e.req) begin bad++; $display("[TB] FAIL %s ped_req got=%b want=%b", e.tag, ped_req, e.req); end
      total++;
      if (press_count !== e.cnt) begin bad++; $display("[TB] FAIL %s press_count got=%0d want=%0d", e.tag, press_count, e.cnt); end
      if (e.ledKnown) begin
        total++;
        if (wait_led !== e.led) begin bad++; $display("[TB] FAIL %s wait_led got=%b want=%b", e.tag, wait_led, e.led); end
      end
    end
    btn_raw = 1'b0;
    repeat (9) step();
    expectNext("release_no_event", 1'b1, 4'd1);
    while (expQ.size() > 0) begin
      step();
      e = expQ.pop_front();
      total++;
      if (press_count !== e.cnt) begin bad++; $display("[TB] FAIL %s press_count got=%0d want=%0d", e.tag, press_count, e.cnt); end
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    for (int i = 1; i <= 20; i++) begin
      btn_raw = 1'b1;
      repeat (8) step();
      btn_raw = 1'b0;
      repeat (7) step();
      expectNext($sformatf("sat_press%0d", i), 1'b1, (i + 1 > 15) ? 4'd15 : 4'(i + 1));
      while (expQ.size() > 0) begin
        step();
        e = expQ.pop_front();
        total++;
        if (press_count !== e.cnt) begin bad++; $display("[TB] FAIL %s press_count got=%0d want=%0d", e.tag, press_count, e.cnt); end
      end
    end
    ped_ack = 1'b1;
    expectNext("ack_clears", 1'b0, 4'd0);
    while (expQ.size() > 0) begin
      step();
      e = expQ.pop_front();
      total++;
      if (ped_req !== e.req) begin bad++; $display("[TB] FAIL %s ped_req got=%b want=%b", e.tag, ped_req, e.req); end
      total++;
      if (press_count !== e.cnt) begin bad++; $display("[TB] FAIL %s press_count got=%0d want=%0d", e.tag, press_count, e.cnt); end
      total++;
      if (wait_led !== e.led) begin bad++; $display("[TB] FAIL %s wait_led got=%b want=%b", e.tag, wait_led, e.led); end
    end
    ped_ack = 1'b0;
  endtask

  // Entered right after the ack edge: the press lands on the 7th hold-off cycle.
  task automatic test_holdoff();
    exp_t e;
    btn_raw = 1'b1;
    for (int k = 1; k <= 12; k++) expectNext($sformatf("holdoff_edge%0d", k), 1'b0, 4'd0);
    while (expQ.size() > 0) begin
      step();
      e = expQ.pop_front();
      total++;
      if (ped_req !== e.req) begin bad++; $display("[TB] FAIL %s ped_req got=%b want=%b", e.tag, ped_req, e.req); end
      total++;
      if (press_count !== e.cnt) begin bad++; $display("[TB] FAIL %s press_count got=%0d want=%0d", e.tag, press_count, e.cnt); end
    end
    btn_raw = 1'b0;
    repeat (10) step();
    btn_raw = 1'b1;
    for (int k = 1; k <= 6; k++) expectNext("post_holdoff_wait", 1'b0, 4'd0);
    expectNext("post_holdoff_press", 1'b1, 4'd1);
    while (expQ.size() > 0) begin
      step();
      e = expQ.pop_front();
      total++;
      if (ped_req !== e.req) begin bad++; $display("[TB] FAIL %s ped_req got=%b want=%b", e.tag, ped_req, e.req); end
      total++;
      if (press_count !== e.cnt) begin bad++; $display("[TB] FAIL %s press_count got=%0d want=%0d", e.tag, press_count, e.cnt); end
    end
  endtask

  task automatic test_ack_collision();
    exp_t e;
    btn_raw = 1'b0;
    repeat (10) step();
    btn_raw = 1'b1;
    for (int k = 1; k <= 6; k++) expectNext("collision_pre", 1'b1, 4'd1);
    while (expQ.size() > 0) begin
      step();
      e = expQ.pop_front();
      total++;
      if (press_count !== e.cnt) begin bad++; $display("[TB] FAIL %s press_count got=%0d want=%0d", e.tag, press_count, e.cnt); end
    end
    ped_ack = 1'b1;
    expectNext("collision_ack_wins", 1'b0, 4'd0);
    while (expQ.size() > 0) begin
      step();
      e = expQ.pop_front();
      total++;
      if (ped_req !== e.req) begin bad++; $display("[TB] FAIL %s ped_req got=%b want=%b", e.tag, ped_req, e.req); end
      total++;
      if (press_count !== e.cnt) begin bad++; $display("[TB] FAIL %s press_count got=%0d want=%0d", e.tag, press_count, e.cnt); end
    end
    ped_ack = 1'b0;
    btn_raw = 1'b0;
    repeat (12) step();
  endtask

  task automatic test_idle_ack();
    exp_t e;
    ped_ack = 1'b1;
    for (int k = 1; k <= 3; k++) expectNext("idle_ack", 1'b0, 4'd0);
    while (expQ.size() > 0) begin
      step();
      e = expQ.pop_front();
      total++;
      if (ped_req !== e.req) begin bad++; $display("[TB] FAIL %s ped_req got=%b want=%b", e.tag, ped_req, e.req); end
      total++;
      if (press_count !== e.cnt) begin bad++; $display("[TB] FAIL %s press_count got=%0d want=%0d", e.tag, press_count, e.cnt); end
    end
    ped_ack = 1'b0;
  endtask

  task automatic test_reset_midop();
    exp_t e;
    btn_raw = 1'b1;
    for (int k = 1; k <= 6; k++) expectNext("midop_pre", 1'b0, 4'd0);
    expectNext("midop_pending", 1'b1, 4'd1);
    rst = 1'b0;
    while (expQ.size() > 0) begin
      step();
      e = expQ.pop_front();
      total++;
      if (ped_req !== e.req) begin bad++; $display("[TB] FAIL %s ped_req got=%b want=%b", e.tag, ped_req, e.req); end
    end
    rst = 1'b1;
    expectNext("midop_reset", 1'b0, 4'd0);
    while (expQ.size() > 0) begin
      step();
      e = expQ.pop_front();
      total++;
      if (ped_req !== e.req) begin bad++; $display("[TB] FAIL %s ped_req got=%b want=%b", e.tag, ped_req, e.req); end
      total++;
      if (press_count !== e.cnt) begin bad++; $display("[TB] FAIL %s press_count got=%0d want=%0d", e.tag, press_count, e.cnt); end
      total++;
      if (wait_led !== e.led) begin bad++; $display("[TB] FAIL %s wait_led got=%b want=%b", e.tag, wait_led, e.led); end
    end
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) expectNext($sformatf("held_thru_reset_edge%0d", k), 1'b0, 4'd0);
    expectNext("held_thru_reset_edge7", 1'b1, 4'd1);
    while (expQ.size() > 0) begin
      step();
      e = expQ.pop_front();
      total++;
      if (ped_req !== e.req) begin bad++; $display("[TB] FAIL %s ped_req got=%b want=%b", e.tag, ped_req, e.req); end
      total++;
      if (press_count !== e.cnt) begin bad++; $display("[TB] FAIL %s press_count got=%0d want=%0d", e.tag, press_count, e.cnt); end
    end
  endtask

  // Starts on the cycle PENDING was entered (LED already 1 in both builds).
  task automatic test_blink();
    exp_t e;
    logic pat [5];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 5; k++) begin
      e.tag      = $sformatf("led_pending%0d", k + 1);
      e.req      = 1'b1;
      e.cnt      = 4'd1;
      e.led      = BLINK_ON ? pat[k] : 1'b1;
      e.ledKnown = 1'b1;
      expQ.push_back(e);
    end
    while (expQ.size() > 0) begin
      step();
      e = expQ.pop_front();
      total++;
      if (wait_led !== e.led) begin bad++; $display("[TB] FAIL %s wait_led got=%b want=%b", e.tag, wait_led, e.led); end
    end
    ped_ack = 1'b1;
    expectNext("led_after_ack", 1'b0, 4'd0);
    while (expQ.size() > 0) begin
      step();
      e = expQ.pop_front();
      total++;
      if (wait_led !== e.led) begin bad++; $display("[TB] FAIL %s wait_led got=%b want=%b", e.tag, wait_led, e.led); end
      total++;
      if (ped_req !== e.req) begin bad++; $display("[TB] FAIL %s ped_req got=%b want=%b", e.tag, ped_req, e.req); end
    end
    ped_ack = 1'b0;
    btn_raw = 1'b0;
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_latency();
    test_saturation();
    test_holdoff();
    test_ack_collision();
    test_idle_ack();
    test_reset_midop();
    test_blink();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
